rx_frame_capture: RTL and testbench
===================================

RX_FRAME_CAPTURE -- requirements
Module: rx_frame_capture

Interface
REQ-001 The module SHALL have parameter DATA_OFFSET, default 4, meaning cycles from vld rising-edge sample to first data-word sample; legal range 1..15.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 The module SHALL have port vld, input, 1, frame-start strobe from the upstream stimulus generator.
REQ-005 The module SHALL have port data, input, 32, data word bus from the upstream stimulus generator.
REQ-006 The module SHALL have port frame_vld, output, 1, one-cycle pulse marking a captured frame.
REQ-007 The module SHALL have port frame_data, output, 64, captured frame {word0, word1}.
REQ-008 The module SHALL have port ovr_err, output, 1, one-cycle pulse on a frame start during an active capture.
REQ-009 The module SHALL have port frame_cnt, output, 16, count of completed frames (see Configuration).

Function
REQ-010 The module SHALL register vld into vld_q each cycle; a start event SHALL be vld=1 and vld_q=0 at a clock edge, defined as edge t0.
REQ-011 The module SHALL implement states IDLE, WAIT, CAP0, CAP1, one-hot or binary.
REQ-012 IDLE -> WAIT SHALL occur on a start event at t0, loading the gap counter with DATA_OFFSET-1.
REQ-013 WAIT SHALL decrement the gap counter each edge; at counter 0 it SHALL go to CAP0, so CAP0 is active at edge t0+DATA_OFFSET (DATA_OFFSET=1 goes IDLE -> CAP0 directly).
REQ-014 In CAP0 the module SHALL latch data as word0 into bits [63:32] and go to CAP1.
REQ-015 In CAP1, at edge t0+DATA_OFFSET+1, the module SHALL latch data as word1 into bits [31:0], drive frame_vld=1 for exactly the following cycle, and return to IDLE.
REQ-016 frame_data SHALL update only on completion and SHALL hold its value until the next completion.
REQ-017 A start event in WAIT, CAP0 or CAP1 SHALL abort the capture, pulse ovr_err for one cycle, emit no frame_vld, and restart at WAIT with the new t0.
REQ-018 A start event in the same edge as a CAP1 completion SHALL complete the frame (frame_vld=1) and start a new capture, with no ovr_err.
REQ-019 vld held high for multiple cycles SHALL produce one start event only.
REQ-020 data SHALL be ignored outside CAP0 and CAP1.
REQ-021 Total latency from t0 to frame_vld high SHALL be DATA_OFFSET+2 edges.

Reset
REQ-022 With rst=1 at an edge, the state SHALL be IDLE, and the following SHALL be 0: the gap counter, frame_vld, frame_data, ovr_err and frame_cnt.
REQ-023 With rst=1 at an edge, vld_q SHALL be 1, so vld already high when reset releases is not a start event.
REQ-024 Reset mid-capture SHALL discard partial words with no frame_vld or ovr_err; rst has priority over all events.

Configuration
REQ-025 With macro RX_FRAME_CAPTURE_CNT_EN defined, frame_cnt SHALL increment by 1 on each frame_vld, wrapping 0xFFFF -> 0x0000; aborted frames SHALL not count.
REQ-026 Without RX_FRAME_CAPTURE_CNT_EN, frame_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-027 DATA_OFFSET=4, vld high for 2 cycles at t0, data 0x08929834 at t0+4 and 0x98343425 at t0+5 -> frame_vld high one cycle after t0+5, frame_data=0x0892983498343425, ovr_err=0.
REQ-028 Second start event at t0+3 during WAIT -> ovr_err pulse, no frame_vld for the first frame; capture completes relative to the new t0 with correct data.
REQ-029 vld held high 10 cycles, data 0xA5A5A5A5 then 0x5A5A5A5A at t0+4/5 -> exactly one frame_vld, frame_data=0xA5A5A5A55A5A5A5A.
REQ-030 rst asserted at t0+4 (CAP0) -> no frame_vld; all outputs 0 after the reset edge; vld high at release does not trigger.
REQ-031 DATA_OFFSET=1, back-to-back start at the completion edge -> two frames, no ovr_err.
REQ-032 With RX_FRAME_CAPTURE_CNT_EN, 3 good frames and 1 aborted frame -> frame_cnt=3; without the macro -> frame_cnt=0.

Source files
------------

// File: rtl/rx_frame_capture.sv
// Captures a two-word frame DATA_OFFSET cycles after a vld rising edge.
// Optional frame counter enabled by defining RX_FRAME_CAPTURE_CNT_EN.
module rx_frame_capture #(
  parameter int unsigned DATA_OFFSET = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [31:0] data,
  output logic        frame_vld,
  output logic [63:0] frame_data,
  output logic        ovr_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned GAP_W   = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FRAME_W = 64;
  localparam int unsigned CNT_W   = 16;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DATA_OFFSET - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAP0,
    ST_CAP1
  } state_e;

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 vld_q, vld_d;
  logic [WORD_W-1:0]    word0_q, word0_d;
  logic [FRAME_W-1:0]   frame_data_q, frame_data_d;
  logic                 frame_vld_q, frame_vld_d;
  logic                 ovr_err_q, ovr_err_d;
  logic                 start_evt;
  logic                 complete;

  assign start_evt = vld & ~vld_q;

  // Next-state: the CAP1 completion is resolved before a coincident start
  // so a start on the completion edge chains into a new capture cleanly.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    vld_d        = vld;
    word0_d      = word0_q;
    frame_data_d = frame_data_q;
    frame_vld_d  = 1'b0;
    ovr_err_d    = 1'b0;
    complete     = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_d == '0) begin
          state_d = ST_CAP0;
        end
      end
      ST_CAP0: begin
        word0_d = data;
        state_d = ST_CAP1;
      end
      ST_CAP1: begin
        frame_data_d = {word0_q, data};
        frame_vld_d  = 1'b1;
        complete     = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_evt) begin
      if ((state_q == ST_WAIT) || (state_q == ST_CAP0)) begin
        ovr_err_d = 1'b1;
      end
      if (DATA_OFFSET == 1) begin
        state_d = ST_CAP0;
        gap_d   = '0;
      end else begin
        state_d = ST_WAIT;
        gap_d   = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      vld_q        <= 1'b1;
      word0_q      <= '0;
      frame_data_q <= '0;
      frame_vld_q  <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      vld_q        <= vld_d;
      word0_q      <= word0_d;
      frame_data_q <= frame_data_d;
      frame_vld_q  <= frame_vld_d;
      ovr_err_q    <= ovr_err_d;
    end
  end

  assign frame_vld  = frame_vld_q;
  assign frame_data = frame_data_q;
  assign ovr_err    = ovr_err_q;

`ifdef RX_FRAME_CAPTURE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts only completed frames; wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (complete) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign frame_cnt = cnt_q;
`else
  logic unused_complete;
  assign unused_complete = complete;
  assign frame_cnt       = CNT_W'(0);
`endif

endmodule

// File: tb/tb_rx_frame_capture.sv
// Bench for rx_frame_capture: instance 0 uses DATA_OFFSET=4, instance 1 uses 1.
module tb_rx_frame_capture;

  localparam int NI = 2;
  localparam int DOFS [NI] = '{4, 1};

  logic        clk;
  logic        rst_i  [NI];
  logic        vld_i  [NI];
  logic [31:0] data_i [NI];
  logic        fv_w   [NI];
  logic [63:0] fd_w   [NI];
  logic        ovr_w  [NI];
  logic [15:0] cnt_w  [NI];

  rx_frame_capture #(.DATA_OFFSET(4)) u_dut_a (
    .clk(clk), .rst(rst_i[0]), .vld(vld_i[0]), .data(data_i[0]),
    .frame_vld(fv_w[0]), .frame_data(fd_w[0]), .ovr_err(ovr_w[0]), .frame_cnt(cnt_w[0])
  );

  rx_frame_capture #(.DATA_OFFSET(1)) u_dut_b (
    .clk(clk), .rst(rst_i[1]), .vld(vld_i[1]), .data(data_i[1]),
    .frame_vld(fv_w[1]), .frame_data(fd_w[1]), .ovr_err(ovr_w[1]), .frame_cnt(cnt_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: tracks the cycle of the latest start and derives outputs
  // from the offset of the current edge relative to it.
  int          cyc = 0;
  logic        act  [NI];
  int          t0   [NI];
  logic        pv   [NI];
  logic [31:0] w0   [NI];
  logic        efv  [NI];
  logic        eovr [NI];
  logic [63:0] efd  [NI];
  logic [15:0] ecnt [NI];
  int          fv_seen  [NI];
  int          ovr_seen [NI];
  logic [63:0] frames_b [$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0; t0[i] = 0; pv[i] = 1'b1; w0[i] = '0;
      efv[i] = 1'b0; eovr[i] = 1'b0; efd[i] = '0; ecnt[i] = '0;
      fv_seen[i] = 0; ovr_seen[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst_i[i]) begin
          act[i] = 1'b0; pv[i] = 1'b1; efv[i] = 1'b0; eovr[i] = 1'b0;
          efd[i] = '0; ecnt[i] = '0;
        end else begin
          logic st;
          int   k;
          st      = vld_i[i] && !pv[i];
          pv[i]   = vld_i[i];
          efv[i]  = 1'b0;
          eovr[i] = 1'b0;
          if (act[i]) begin
            k = cyc - t0[i];
            if (k == DOFS[i]) w0[i] = data_i[i];
            else if (k == DOFS[i] + 1) begin
              efd[i] = {w0[i], data_i[i]};
              efv[i] = 1'b1;
              act[i] = 1'b0;
`ifdef RX_FRAME_CAPTURE_CNT_EN
              ecnt[i] = ecnt[i] + 16'd1;
`endif
            end
          end
          if (st) begin
            if (act[i]) eovr[i] = 1'b1;
            act[i] = 1'b1;
            t0[i]  = cyc;
          end
        end
      end
      cyc++;
      #1;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("frame_vld[%0d]", i),  64'(fv_w[i]),  64'(efv[i]));
        chk($sformatf("ovr_err[%0d]", i),    64'(ovr_w[i]), 64'(eovr[i]));
        chk($sformatf("frame_data[%0d]", i), fd_w[i],       efd[i]);
        chk($sformatf("frame_cnt[%0d]", i),  64'(cnt_w[i]), 64'(ecnt[i]));
        if (fv_w[i] === 1'b1) fv_seen[i]++;
        if (ovr_w[i] === 1'b1) ovr_seen[i]++;
        if (i == 1 && fv_w[i] === 1'b1) frames_b.push_back(fd_w[i]);
      end
    end
  end

  task automatic step(input int i, input logic r, input logic v, input logic [31:0] d);
    rst_i[i]  = r;
    vld_i[i]  = v;
    data_i[i] = d;
    @(negedge clk);
  endtask

  task automatic idle(input int i, input int n);
    for (int j = 0; j < n; j++) step(i, 1'b0, 1'b0, 32'hDEAD_BEEF ^ 32'(j));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_i[i] = 1'b1; vld_i[i] = 1'b0; data_i[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;

    chk("rst_frame_vld",  64'(fv_w[0]),  64'd0);
    chk("rst_frame_data", fd_w[0],       64'd0);
    chk("rst_ovr_err",    64'(ovr_w[0]), 64'd0);
    chk("rst_frame_cnt",  64'(cnt_w[0]), 64'd0);
    idle(0, 2);

    // Basic capture, vld held for two cycles
    step(0, 1'b0, 1'b1, 32'h0000_0001);
    step(0, 1'b0, 1'b1, 32'h0000_0002);
    step(0, 1'b0, 1'b0, 32'h0000_0003);
    step(0, 1'b0, 1'b0, 32'h0000_0004);
    step(0, 1'b0, 1'b0, 32'h0892_9834);
    step(0, 1'b0, 1'b0, 32'h9834_3425);
    idle(0, 3);
    chk("basic_frames", 64'(fv_seen[0]),  64'd1);
    chk("basic_ovr",    64'(ovr_seen[0]), 64'd0);
    chk("basic_data",   fd_w[0],          64'h0892_9834_9834_3425);

    // Restart during WAIT aborts the first capture
    step(0, 1'b0, 1'b1, 32'h7777_0000);
    step(0, 1'b0, 1'b0, 32'h7777_0001);
    step(0, 1'b0, 1'b0, 32'h7777_0002);
    step(0, 1'b0, 1'b1, 32'h7777_0003);
    step(0, 1'b0, 1'b0, 32'h7777_0004);
    step(0, 1'b0, 1'b0, 32'h7777_0005);
    step(0, 1'b0, 1'b0, 32'h7777_0006);
    step(0, 1'b0, 1'b0, 32'h1111_2222);
    step(0, 1'b0, 1'b0, 32'h3333_4444);
    idle(0, 3);
    chk("abort_frames", 64'(fv_seen[0]),  64'd2);
    chk("abort_ovr",    64'(ovr_seen[0]), 64'd1);
    chk("abort_data",   fd_w[0],          64'h1111_2222_3333_4444);

    // vld held for ten cycles yields a single frame
    for (int j = 0; j < 10; j++) begin
      logic [31:0] d;
      d = (j == 4) ? 32'hA5A5_A5A5 : (j == 5) ? 32'h5A5A_5A5A : 32'h0BAD_0000 + 32'(j);
      step(0, 1'b0, 1'b1, d);
    end
    idle(0, 3);
    chk("held_frames", 64'(fv_seen[0]),  64'd3);
    chk("held_ovr",    64'(ovr_seen[0]), 64'd1);
    chk("held_data",   fd_w[0],          64'hA5A5_A5A5_5A5A_5A5A);
`ifdef RX_FRAME_CAPTURE_CNT_EN
    chk("cnt_three", 64'(cnt_w[0]), 64'd3);
`else
    chk("cnt_off",   64'(cnt_w[0]), 64'd0);
`endif

    // Reset during CAP0 with vld high through release
    step(0, 1'b0, 1'b1, 32'h2222_0000);
    step(0, 1'b0, 1'b1, 32'h2222_0001);
    step(0, 1'b0, 1'b1, 32'h2222_0002);
    step(0, 1'b0, 1'b1, 32'h2222_0003);
    step(0, 1'b1, 1'b1, 32'h2222_0004);
    chk("rstcap_frame_vld",  64'(fv_w[0]),  64'd0);
    chk("rstcap_frame_data", fd_w[0],       64'd0);
    chk("rstcap_ovr_err",    64'(ovr_w[0]), 64'd0);
    chk("rstcap_frame_cnt",  64'(cnt_w[0]), 64'd0);
    for (int j = 0; j < 8; j++) step(0, 1'b0, 1'b1, 32'h3333_0000 + 32'(j));
    idle(0, 2);
    chk("rstcap_frames", 64'(fv_seen[0]),  64'd3);
    chk("rstcap_ovr",    64'(ovr_seen[0]), 64'd1);

    // DATA_OFFSET=1 with a new start on the completion edge
    idle(1, 2);
    step(1, 1'b0, 1'b1, 32'h0000_00FF);
    step(1, 1'b0, 1'b0, 32'hCAFE_0001);
    step(1, 1'b0, 1'b1, 32'hCAFE_0002);
    step(1, 1'b0, 1'b0, 32'hBEEF_0003);
    step(1, 1'b0, 1'b0, 32'hBEEF_0004);
    idle(1, 3);
    chk("b2b_frames", 64'(fv_seen[1]),  64'd2);
    chk("b2b_ovr",    64'(ovr_seen[1]), 64'd0);
    chk("b2b_nframes_q", 64'(frames_b.size()), 64'd2);
    if (frames_b.size() == 2) begin
      chk("b2b_first",  frames_b[0], 64'hCAFE_0001_CAFE_0002);
      chk("b2b_second", frames_b[1], 64'hBEEF_0003_BEEF_0004);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
